spram_burst_ctrl: RTL and testbench

Burst access controller sitting directly upstream of the 64KB single-port RAM. Accepts read/write burst commands over valid/ready, streams write data into the RAM one beat per cycle, and returns read data through a 4-entry return buffer with backpressure. Drives the RAM's `addr`, `data_in` and `rdn_wr` pins and consumes its `data_out`. The RAM has one-cycle read latency.

---
 rtl/spram_burst_ctrl_if.sv | 29 ++
 rtl/spram_burst_ctrl.sv | 146 ++++++++++++++
 tb/tb_spram_burst_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spram_burst_ctrl_if.sv
// rtl/spram_burst_ctrl_if.sv - command, write-data and read-data streams of spram_burst_ctrl
interface spram_burst_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/spram_burst_ctrl.sv
// rtl/spram_burst_ctrl.sv - burst read/write controller for a single-port RAM with 4-entry read return buffer
// SPRAM_BURST_WRAP_ERR_EN: reject (err pulse) bursts that would run past the top address.
module spram_burst_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_p,
  spram_burst_ctrl_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_rdn_wr,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur;
  logic [LEN_WIDTH:0]    beats_left;
  logic                  cmd_ready_c, wr_ready_c, busy_c, issue;
  logic                  cmd_fire, wr_fire, rd_fire, bad_cmd;
  logic                  v1, v2, last1, last2;
  logic [DATA_WIDTH-1:0] buf_data [4];
  logic                  buf_last [4];
  logic [1:0]            wptr, rptr;
  logic [2:0]            occ, credit_used;
  logic                  rd_valid_c;

  assign rd_valid_c    = (occ != 3'd0);
  assign cmd_fire      = bus.cmd_valid && cmd_ready_c;
  assign wr_fire       = bus.wr_valid && wr_ready_c;
  assign rd_fire       = rd_valid_c && bus.rd_ready;
  // Reads issued but not yet captured still own a buffer slot.
  assign credit_used   = occ + {2'b0, v1} + {2'b0, v2};

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.wr_ready  = wr_ready_c;
  assign bus.rd_valid  = rd_valid_c;
  assign bus.rd_data   = buf_data[rptr];
  assign bus.rd_last   = rd_valid_c && buf_last[rptr];
  assign busy          = busy_c;

`ifdef SPRAM_BURST_WRAP_ERR_EN
  assign bad_cmd = ({1'b0, bus.cmd_addr} + (ADDR_WIDTH+1)'(bus.cmd_len)) > {1'b0, {ADDR_WIDTH{1'b1}}};

  always_ff @(posedge clk) begin
    if (rst_p) err <= 1'b0;
    else       err <= cmd_fire && bad_cmd;
  end
`else
  assign bad_cmd = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_p) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_fire && !bad_cmd) state_nxt = bus.cmd_wr ? ST_WRITE : ST_READ;
      ST_WRITE: if (beats_left == '0) state_nxt = ST_IDLE;
      ST_READ:  if (rd_fire && bus.rd_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_c = 1'b0;
    wr_ready_c  = 1'b0;
    busy_c      = 1'b0;
    issue       = 1'b0;
    case (state)
      ST_IDLE:  cmd_ready_c = !rst_p;
      ST_WRITE: begin
        busy_c     = 1'b1;
        wr_ready_c = (beats_left != '0);
      end
      ST_READ:  begin
        busy_c = 1'b1;
        issue  = (beats_left != '0) && (credit_used < 3'd4);
      end
      default:  busy_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      cur         <= '0;
      beats_left  <= '0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      ram_rdn_wr  <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      last1       <= 1'b0;
      last2       <= 1'b0;
      done        <= 1'b0;
    end else begin
      ram_rdn_wr <= wr_fire;
      done       <= ((state == ST_WRITE) && (beats_left == '0)) ||
                    ((state == ST_READ) && rd_fire && bus.rd_last);
      if (cmd_fire) begin
        cur        <= bus.cmd_addr;
        beats_left <= {1'b0, bus.cmd_len} + (LEN_WIDTH+1)'(1);
      end else if (wr_fire || issue) begin
        cur        <= cur + ADDR_WIDTH'(1);
        beats_left <= beats_left - (LEN_WIDTH+1)'(1);
      end
      if (wr_fire || issue) ram_addr <= cur;
      if (wr_fire) ram_data_in <= bus.wr_data;
      // Two-stage tag pipe matches address register + RAM read latency.
      v1    <= issue;
      last1 <= issue && (beats_left == (LEN_WIDTH+1)'(1));
      v2    <= v1;
      last2 <= last1;
    end
  end

  always_ff @(posedge clk) begin
    if (v2) begin
      buf_data[wptr] <= ram_data_out;
      buf_last[wptr] <= last2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      wptr <= 2'd0;
      rptr <= 2'd0;
      occ  <= 3'd0;
    end else begin
      if (v2)      wptr <= wptr + 2'd1;
      if (rd_fire) rptr <= rptr + 2'd1;
      occ <= occ + {2'b0, v2} - {2'b0, rd_fire};
    end
  end

endmodule

// File: tb/tb_spram_burst_ctrl.sv
// tb/tb_spram_burst_ctrl.sv - directed + randomized bench for spram_burst_ctrl against a golden memory model
module tb_spram_burst_ctrl;

`ifdef SPRAM_BURST_WRAP_ERR_EN
  localparam bit WRAP_ERR = 1'b1;
`else
  localparam bit WRAP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_p;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data_in;
  logic        ram_rdn_wr;
  logic [7:0]  ram_data_out;
  logic        busy, done, err;

  spram_burst_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LEN_WIDTH(8)) bus ();

  spram_burst_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst_p(rst_p), .bus(bus),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_rdn_wr(ram_rdn_wr),
    .ram_data_out(ram_data_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [65536];
  always @(posedge clk) begin
    if (ram_rdn_wr) ram[ram_addr] <= ram_data_in;
    ram_data_out <= ram[ram_addr];
  end

  typedef struct { int c; logic [15:0] a; logic [7:0] d; } wbeat_t;
  typedef struct { int c; logic [7:0] d; logic l; } rbeat_t;

  logic [7:0] gold [65536];
  wbeat_t     wlog[$];
  rbeat_t     rlog[$];
  int         done_log[$];
  int         err_log[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic sample();
    #1;
    if (ram_rdn_wr) wlog.push_back('{cyc, ram_addr, ram_data_in});
    if (bus.rd_valid && bus.rd_ready) rlog.push_back('{cyc, bus.rd_data, bus.rd_last});
    if (done) done_log.push_back(cyc);
    if (err) err_log.push_back(cyc);
  endtask

  task automatic send_cmd(input bit wr, input logic [15:0] addr, input int len, output int t_acc);
    wlog.delete(); rlog.delete(); done_log.delete(); err_log.delete();
    tick();
    bus.cmd_valid = 1'b1; bus.cmd_wr = wr; bus.cmd_addr = addr; bus.cmd_len = 8'(len);
    sample();
    chk("cmd_ready", bus.cmd_ready, 1);
    t_acc = cyc;
  endtask

  task automatic do_write(input logic [15:0] addr, input int len, input int vprob,
                          input int holdoff, input int seed);
    logic [7:0]  dq[$];
    int          hs_c[$];
    int          t_acc, idx, beats;
    bit          bad, busy1, saw_wr;
    logic [15:0] a;
    beats = len + 1;
    for (int i = 0; i < beats; i++) dq.push_back(seed >= 0 ? 8'(seed + i) : 8'($urandom));
    bad = WRAP_ERR && (int'(addr) + len > 65535);
    send_cmd(1'b1, addr, len, t_acc);
    idx = 0; saw_wr = 0; busy1 = 0;
    for (int k = 0; k < beats * 20 + holdoff + 20; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = 16'($urandom);
      bus.wr_valid  = (k >= holdoff) && ($urandom_range(99) < vprob);
      bus.wr_data   = (idx < beats) ? dq[idx] : 8'($urandom);
      sample();
      if (k == 0) busy1 = busy;
      if (bus.wr_ready) saw_wr = 1;
      if (bus.wr_valid && bus.wr_ready) begin hs_c.push_back(cyc); idx++; end
      if (done) chk("wr_done_idle", {bus.cmd_ready, busy}, 2'b10);
      if (done_log.size() > 0 || (bad && k >= 6)) break;
    end
    bus.wr_valid = 1'b0;
    chk("wr_busy_t1", busy1, !bad);
    chk("wr_err_cnt", err_log.size(), bad);
    chk("wr_beats", wlog.size(), bad ? 0 : beats);
    chk("wr_done_cnt", done_log.size(), bad ? 0 : 1);
    if (bad) begin
      chk("wr_err_t1", err_log.size() > 0 ? err_log[0] : -1, t_acc + 1);
      chk("wr_ready_blocked", saw_wr, 0);
    end else begin
      if (vprob == 100 && hs_c.size() > 0) chk("wr_first_hs", hs_c[0], t_acc + 1 + holdoff);
      for (int i = 0; i < beats && i < wlog.size() && i < hs_c.size(); i++) begin
        a = addr + 16'(i);
        chk("wr_addr", wlog[i].a, a);
        chk("wr_data", wlog[i].d, dq[i]);
        chk("wr_cycle", wlog[i].c, hs_c[i] + 1);
        gold[a] = dq[i];
      end
      if (done_log.size() > 0 && wlog.size() > 0)
        chk("wr_done_cycle", done_log[0], wlog[wlog.size()-1].c + 1);
    end
  endtask

  task automatic do_read(input logic [15:0] addr, input int len, input int rprob, input int stall);
    int          t_acc, beats;
    bit          bad, busy1, saw_wr;
    logic [15:0] a;
    beats = len + 1;
    bad = WRAP_ERR && (int'(addr) + len > 65535);
    bus.rd_ready = 1'b0;
    send_cmd(1'b0, addr, len, t_acc);
    saw_wr = 0; busy1 = 0;
    for (int k = 0; k < beats * 20 + stall + 20; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      bus.rd_ready  = (k >= stall) && ($urandom_range(99) < rprob);
      bus.wr_valid  = 1'($urandom_range(1));
      sample();
      if (k == 0) busy1 = busy;
      if (bus.wr_ready) saw_wr = 1;
      if (!bad && stall >= 4 && k == stall - 1) begin
        chk("rd_stall_addr", ram_addr, addr + 16'(len < 3 ? len : 3));
        chk("rd_stall_valid", bus.rd_valid, 1);
      end
      if (done) chk("rd_done_idle", {bus.cmd_ready, busy}, 2'b10);
      if (done_log.size() > 0 || (bad && k >= 6)) break;
    end
    bus.rd_ready = 1'b0;
    bus.wr_valid = 1'b0;
    chk("rd_busy_t1", busy1, !bad);
    chk("rd_err_cnt", err_log.size(), bad);
    chk("rd_beats", rlog.size(), bad ? 0 : beats);
    chk("rd_done_cnt", done_log.size(), bad ? 0 : 1);
    chk("rd_wr_gated", saw_wr, 0);
    chk("rd_no_ram_wr", wlog.size(), 0);
    for (int i = 0; i < rlog.size() && i < beats; i++) begin
      a = addr + 16'(i);
      chk("rd_data", rlog[i].d, gold[a]);
      chk("rd_last", rlog[i].l, i == beats - 1);
      if (rprob == 100 && stall == 0) chk("rd_cycle", rlog[i].c, t_acc + 4 + i);
    end
    if (done_log.size() > 0 && rlog.size() > 0)
      chk("rd_done_cycle", done_log[0], rlog[rlog.size()-1].c + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t_acc;
    rst_p = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;

    repeat (3) begin tick(); rst_p = 1'b1; sample(); end
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_last", bus.rd_last, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data_in", ram_data_in, 0);
    chk("rst_ram_rdn_wr", ram_rdn_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    tick(); rst_p = 1'b0; sample();
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);
    chk("post_rst_busy", busy, 0);

    do_write(16'h0010, 3, 100, 0, 8'hA0);
    do_read(16'h0010, 3, 100, 0);
    do_write(16'hFF00, 255, 100, 0, -1);
    do_write(16'h0000, 255, 100, 0, -1);
    do_read(16'hFF00, 255, 100, 0);
    do_read(16'h0000, 7, 100, 10);
    do_write(16'hFFFF, 2, 100, 0, -1);
    do_read(16'hFFFF, 2, 100, 0);
    do_write(16'h0030, 0, 100, 3, -1);
    do_read(16'h0030, 0, 100, 0);

    // Reset while the third beat of an 8-beat read is on the return port.
    send_cmd(1'b0, 16'h0020, 7, t_acc);
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      if (rlog.size() == 2) begin rst_p = 1'b1; bus.rd_ready = 1'b0; end
      sample();
      if (rst_p) break;
    end
    tick(); rst_p = 1'b0; bus.rd_ready = 1'b1; sample();
    chk("mid_rst_seen_beats", rlog.size(), 2);
    chk("mid_rst_rd_valid", bus.rd_valid, 0);
    chk("mid_rst_rd_last", bus.rd_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    chk("mid_rst_ram_data_in", ram_data_in, 0);
    chk("mid_rst_ram_rdn_wr", ram_rdn_wr, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
    chk("mid_rst_wr_ready", bus.wr_ready, 0);
    rlog.delete();
    repeat (6) begin tick(); sample(); end
    chk("mid_rst_no_stale", rlog.size(), 0);
    bus.rd_ready = 1'b0;
    do_write(16'h0020, 7, 100, 0, -1);
    do_read(16'h0020, 7, 100, 0);

    for (int n = 0; n < 24; n++) begin
      logic [15:0] a;
      int          l;
      a = 16'hFF00 + 16'($urandom_range(0, 495));
      l = $urandom_range(0, 15);
      if ($urandom_range(1) == 1) do_write(a, l, $urandom_range(40, 100), $urandom_range(0, 2), -1);
      else                        do_read(a, l, $urandom_range(40, 100), $urandom_range(0, 1) * 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
